// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with qualified input, SOF realignment and a
// single-entry valid/ready output holding register with overrun/framing pulses.
module sipo_deser #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_sof,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             frame_err
);
  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("sipo_deser: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_done;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  // An SOF bit always opens a fresh word, so it can never complete one.
  assign w_done = sin_valid & ~sin_sof & w_last;

  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    if (MSB_FIRST) w_sreg_nxt = {r_sreg[WIDTH-2:0], sin_data};
    else           w_sreg_nxt = {sin_data, r_sreg[WIDTH-1:1]};
    if (sin_sof)     w_cnt_nxt = CNT_W'(1);
    else if (w_last) w_cnt_nxt = '0;
    else             w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Stale bits left in r_sreg after a realign are shifted out before completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sreg     <= '0;
      r_cnt      <= '0;
      pout_data  <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (sin_valid) begin
        r_sreg    <= w_sreg_nxt;
        r_cnt     <= w_cnt_nxt;
        frame_err <= sin_sof && (r_cnt != '0);
      end
      if (w_done) begin
        if (!pout_valid || pout_ready) begin
          pout_data  <= w_sreg_nxt;
          pout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: one MSB-first and one LSB-first instance share
// the serial stream; expected words are queued per instance and popped on consume.
module tb_sipo_deser;
  logic       clk = 1'b0;
  logic       rst_n, sin_valid, sin_data, sin_sof, pout_ready;
  logic [9:0] pd_m, pd_l;
  logic       pv_m, pv_l, ov_m, ov_l, fe_m, fe_l;

  int errors = 0;
  int checks = 0;
  int ovc_m, ovc_l, fec_m, fec_l;
  logic [9:0] q_m[$];
  logic [9:0] q_l[$];
  logic [9:0] em, el;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(10), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
    .pout_data(pd_m), .pout_valid(pv_m), .pout_ready(pout_ready), .overrun(ov_m), .frame_err(fe_m));

  sipo_deser #(.WIDTH(10), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
    .pout_data(pd_l), .pout_valid(pv_l), .pout_ready(pout_ready), .overrun(ov_l), .frame_err(fe_l));

  function automatic logic [9:0] rev10(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return r;
  endfunction

  // Consumed words are popped and compared; pulses are counted per cycle high.
  always @(negedge clk) begin
    if (pv_m === 1'b1 && pout_ready === 1'b1) begin
      checks++;
      if (q_m.size() == 0) begin
        errors++;
        $display("FAIL sb_msb: got word %h, expected none", pd_m);
      end else begin
        em = q_m.pop_front();
        if (pd_m !== em) begin
          errors++;
          $display("FAIL sb_msb: got %h, expected %h", pd_m, em);
        end
      end
    end
    if (pv_l === 1'b1 && pout_ready === 1'b1) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++;
        $display("FAIL sb_lsb: got word %h, expected none", pd_l);
      end else begin
        el = q_l.pop_front();
        if (pd_l !== el) begin
          errors++;
          $display("FAIL sb_lsb: got %h, expected %h", pd_l, el);
        end
      end
    end
    if (ov_m === 1'b1) ovc_m++;
    if (ov_l === 1'b1) ovc_l++;
    if (fe_m === 1'b1) fec_m++;
    if (fe_l === 1'b1) fec_l++;
  end

  task automatic cyc(input logic v, input logic d, input logic s);
    sin_valid = v; sin_data = d; sin_sof = s;
    @(posedge clk); #1;
    sin_valid = 1'b0; sin_sof = 1'b0;
  endtask

  // Sends the top n bits of w, w[9] first; 3 idle cycles after bit ga and bit gb.
  task automatic send_bits(input logic [9:0] w, input int n, input bit sof, input int ga, input int gb);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, w[9-i], sof && (i == 0));
      if (i + 1 == ga || i + 1 == gb) repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic clr_cnt();
    ovc_m = 0; ovc_l = 0; fec_m = 0; fec_l = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pout_ready = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if ({pv_m, pd_m, ov_m, fe_m} !== 13'h0) begin
      errors++; $display("FAIL reset_msb: got v=%b d=%h o=%b f=%b, expected all 0", pv_m, pd_m, ov_m, fe_m);
    end
    checks++;
    if ({pv_l, pd_l, ov_l, fe_l} !== 13'h0) begin
      errors++; $display("FAIL reset_lsb: got v=%b d=%h o=%b f=%b, expected all 0", pv_l, pd_l, ov_l, fe_l);
    end
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    clr_cnt(); pout_ready = 1'b1;
    q_m.push_back(10'h2CE); q_l.push_back(10'h1CD);
    send_bits(10'h2CE, 10, 1'b1, 0, 0);
    checks++;
    if (pv_m !== 1'b1 || pd_m !== 10'h2CE) begin
      errors++; $display("FAIL basic_latency: got v=%b d=%h, expected v=1 d=2ce", pv_m, pd_m);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (pv_m !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: got v=%b, expected 0", pv_m);
    end
  endtask

  task automatic test_lsb_first();
    clr_cnt(); pout_ready = 1'b1;
    q_m.push_back(10'h2CE); q_l.push_back(10'h1CD);
    send_bits(10'h2CE, 10, 1'b1, 0, 0);
    checks++;
    if (pv_l !== 1'b1 || pd_l !== 10'h1CD) begin
      errors++; $display("FAIL lsb_first: got v=%b d=%h, expected v=1 d=1cd", pv_l, pd_l);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    clr_cnt(); pout_ready = 1'b1;
    q_m.push_back(10'h2CE); q_l.push_back(10'h1CD);
    send_bits(10'h2CE, 10, 1'b1, 2, 7);
    checks++;
    if (pv_m !== 1'b1 || pd_m !== 10'h2CE) begin
      errors++; $display("FAIL gaps: got v=%b d=%h, expected v=1 d=2ce", pv_m, pd_m);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_realign();
    clr_cnt(); pout_ready = 1'b1;
    send_bits(10'h2C0, 4, 1'b1, 0, 0);
    q_m.push_back(10'h3FF); q_l.push_back(10'h3FF);
    send_bits(10'h3FF, 10, 1'b1, 0, 0);
    checks++;
    if (pv_m !== 1'b1 || pd_m !== 10'h3FF) begin
      errors++; $display("FAIL realign_word: got v=%b d=%h, expected v=1 d=3ff", pv_m, pd_m);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (fec_m != 1 || fec_l != 1) begin
      errors++; $display("FAIL realign_frame_err: got pulses %0d/%0d, expected 1/1", fec_m, fec_l);
    end
  endtask

  task automatic test_backpressure();
    clr_cnt(); pout_ready = 1'b0;
    q_m.push_back(10'h155); q_l.push_back(rev10(10'h155));
    send_bits(10'h155, 10, 1'b1, 0, 0);
    send_bits(10'h0AA, 10, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (pv_m !== 1'b1 || pd_m !== 10'h155) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h, expected v=1 d=155", pv_m, pd_m);
    end
    checks++;
    if (ovc_m != 1 || ovc_l != 1) begin
      errors++; $display("FAIL bp_overrun: got pulses %0d/%0d, expected 1/1", ovc_m, ovc_l);
    end
    pout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (pv_m !== 1'b0 || pv_l !== 1'b0) begin
      errors++; $display("FAIL bp_release: got v=%b/%b, expected 0/0", pv_m, pv_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] w [3];
    clr_cnt(); pout_ready = 1'b1;
    w[0] = 10'h123; w[1] = 10'h3C5; w[2] = 10'h0F0;
    for (int k = 0; k < 3; k++) begin
      q_m.push_back(w[k]); q_l.push_back(rev10(w[k]));
    end
    for (int k = 0; k < 3; k++) begin
      send_bits(w[k], 10, k == 0, 0, 0);
      checks++;
      if (pv_m !== 1'b1 || pd_m !== w[k]) begin
        errors++; $display("FAIL b2b_word%0d: got v=%b d=%h, expected v=1 d=%h", k, pv_m, pd_m, w[k]);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (ovc_m != 0 || fec_m != 0) begin
      errors++; $display("FAIL b2b_pulses: got ov=%0d fe=%0d, expected 0/0", ovc_m, fec_m);
    end
  endtask

  task automatic test_reset_mid_word();
    clr_cnt(); pout_ready = 1'b0;
    send_bits(10'h0F0, 10, 1'b1, 0, 0);
    send_bits(10'h3AB, 5, 1'b0, 0, 0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if ({pv_m, pd_m, ov_m, fe_m} !== 13'h0 || {pv_l, pd_l} !== 11'h0) begin
      errors++; $display("FAIL midrst_outputs: got v=%b d=%h o=%b f=%b, expected all 0", pv_m, pd_m, ov_m, fe_m);
    end
    rst_n = 1'b1; pout_ready = 1'b1;
    q_m.push_back(10'h201); q_l.push_back(10'h201);
    send_bits(10'h201, 10, 1'b0, 0, 0);
    checks++;
    if (pv_m !== 1'b1 || pd_m !== 10'h201) begin
      errors++; $display("FAIL midrst_word: got v=%b d=%h, expected v=1 d=201", pv_m, pd_m);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (fec_m != 0 || fec_l != 0) begin
      errors++; $display("FAIL midrst_frame_err: got pulses %0d/%0d, expected 0/0", fec_m, fec_l);
    end
  endtask

  initial begin
    sin_valid = 1'b0; sin_data = 1'b0; sin_sof = 1'b0; pout_ready = 1'b1; rst_n = 1'b0;
    clr_cnt();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_lsb_first();
    test_gaps();
    test_realign();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d/%0d words pending, expected 0/0", q_m.size(), q_l.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-to-parallel deserializer; next generation of the fixed 10-bit shifter in the DSP48A1 test datapath.
- Adds:
  - configurable word width and bit order;
  - a qualified serial input;
  - a start-of-word alignment strobe;
  - a valid/ready output handshake with overrun and framing-error reporting.
- Feeds parallel operand words into downstream DSP operand registers, which may stall.

Parameters:
- WIDTH, 10, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in pout_data[WIDTH-1]; 0 = first received bit lands in pout_data[0].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sin_valid  in  1  qualifies sin_data; a bit is accepted only when high.
- sin_data  in  1  serial data bit.
- sin_sof  in  1  marks the accepted bit as first bit of a word; ignored when sin_valid=0.
- pout_data  out  WIDTH  assembled parallel word.
- pout_valid  out  1  pout_data holds an unconsumed word.
- pout_ready  in  1  consumer accepts the word when pout_valid & pout_ready.
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- frame_err  out  1  one-cycle pulse: sin_sof arrived with a partial word pending.

Behaviour:
- Reset (rst_n=0 at an edge):
  - shift register, bit counter, pout_data, pout_valid, overrun and frame_err all go to 0.
  - Reset mid-word discards the partial word. The first accepted bit after reset is bit 0 of a new word.
- Bit counter:
  - cnt, width $clog2(WIDTH), range 0..WIDTH-1.
  - Increments only on an accepted bit.
  - sin_valid=0 cycles freeze cnt and the shift register (gaps are allowed anywhere).
- Shift:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin_data}.
  - MSB_FIRST=0: sreg <= {sin_data, sreg[WIDTH-1:1]}.
- Alignment:
  - An accepted bit with sin_sof=1 starts a new word: that bit is shifted in as bit 0 and cnt <= 1.
  - If cnt != 0 at that time, frame_err pulses high the next cycle and the partial word is discarded.
  - sin_sof with cnt == 0: no error.
- Word completion:
  - Occurs on the accepted bit where cnt == WIDTH-1 and sin_sof=0. cnt wraps to 0.
  - The completed word is sreg after including that bit.
- Output stage (single holding register):
  - On completion, if pout_valid=0 or pout_ready=1 in that cycle: pout_data <= word and pout_valid <= 1 at the same edge. Latency is 1 clock from the last bit's sampling edge.
  - On completion with pout_valid=1 and pout_ready=0: the word is dropped, pout_data/pout_valid are unchanged, and overrun pulses for 1 cycle.
  - Consume (pout_valid & pout_ready) with no completion in the same cycle: pout_valid <= 0. pout_data holds its last value.
  - Consume and completion in the same cycle: the new word loads and pout_valid stays 1 (full throughput, no bubble).
- pout_data must be stable while pout_valid=1 and pout_ready=0.
- overrun and frame_err are registered, never combinational. Both may pulse in the same cycle.
- Sustained throughput: one word per WIDTH accepted bits, no dead cycles between words.

Decomposition:
- No shared-package content is required.
- CNT_W = $clog2(WIDTH) is a localparam inside the block.
- Single flat module; no sub-module is natural at this size.
- A WIDTH range check (2..32) is done at elaboration via a generate-time error.

Test Plan:
- Basic MSB-first:
  - Stimulus: WIDTH=10, MSB_FIRST=1, pout_ready=1, continuous sin_valid, bits 1,0,1,1,0,0,1,1,1,0 (sof on first).
  - Response: pout_data=10'h2CE with pout_valid=1 for exactly one cycle, on the cycle after the 10th bit.
- LSB-first:
  - Stimulus: same bit stream with MSB_FIRST=0.
  - Response: pout_data=10'h1CD.
- Gaps:
  - Stimulus: same stream with sin_valid low for 3 cycles after bits 2 and 7.
  - Response: pout_data=10'h2CE, delivered 1 cycle after the last accepted bit.
- Realign:
  - Stimulus: 4 bits sent, then sin_sof with 10 bits of 10'h3FF.
  - Response: frame_err pulses once; next word = 10'h3FF; no partial word is emitted.
- Backpressure:
  - Stimulus: pout_ready=0; send words 10'h155 then 10'h0AA back-to-back.
  - Response: pout_data stays 10'h155 with pout_valid=1; overrun pulses once when 10'h0AA completes.
  - Then raise pout_ready: pout_valid drops the next cycle.
- Reset mid-word:
  - Stimulus: 5 bits sent, rst_n low for 1 cycle, then 10 bits of 10'h201 (no sof).
  - Response: all outputs 0 after reset; next word = 10'h201; no frame_err.
